chan_512_packet_start_ctrl: RTL and testbench

- Consumes the 32-bit start-buffer control word, already in the user_clk domain, from the software-written start register.
- Arms on a software start request, waits for the channelizer frame sync, then writes NUM_FRAMES×N_CHAN channel samples into the packet buffer.
- Reports busy/done status back to software.
- Sits between the start-buffer register and the packet BRAM write port.

---
 rtl/chan_pkt_pkg.sv | 21 ++
 rtl/chan_pkt_edge_det.sv | 18 +
 rtl/chan_512_packet_start_ctrl.sv | 166 ++++++++++++++++
 tb/tb_chan_512_packet_start_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/chan_pkt_pkg.sv
// chan_pkt_pkg: shared FSM state encoding and control/status word bit positions for the packet start controller
package chan_pkt_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_CAPTURE,
        S_DONE
    } state_e;

    localparam int START_BIT   = 0;
    localparam int ABORT_BIT   = 1;
    localparam int NFRAMES_LSB = 16;
    localparam int NFRAMES_W   = 16;

    localparam int BUSY_BIT    = 0;
    localparam int DONE_BIT    = 1;
    localparam int OVF_BIT     = 2;
    localparam int FRAMES_LSB  = 16;

endpackage

// File: rtl/chan_pkt_edge_det.sv
// chan_pkt_edge_det: single-bit rising-edge detector with synchronous active-high reset
module chan_pkt_edge_det (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic rise_o
);

    logic d_q;

    // Previous-cycle copy of the input; cleared by reset so a level held through reset reads as an edge
    always_ff @(posedge clk_i) begin
        d_q <= rst_i ? 1'b0 : d_i;
    end

    assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/chan_512_packet_start_ctrl.sv
// chan_512_packet_start_ctrl: arms on a software start, aligns to channelizer frame sync and writes
// num_frames x N_CHAN samples into the packet buffer. Optional macro CHAN_PKT_START_TIMESTAMP_EN adds ts_out.
module chan_512_packet_start_ctrl
    import chan_pkt_pkg::*;
#(
    parameter int N_CHAN = 512,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16
) (
    input  logic              user_clk,
    input  logic              user_rst,
    input  logic [31:0]       ctrl_word,
    input  logic              sync_in,
    input  logic              ch_valid,
    input  logic [DATA_W-1:0] ch_data,
    output logic              buf_we,
    output logic [ADDR_W-1:0] buf_addr,
    output logic [DATA_W-1:0] buf_data,
    output logic [31:0]       status
`ifdef CHAN_PKT_START_TIMESTAMP_EN
    ,
    output logic [31:0]       ts_out
`endif
);

    localparam int CW = (N_CHAN > 1) ? $clog2(N_CHAN) : 1;
    localparam logic [CW-1:0] LAST_CH = CW'(N_CHAN - 1);

    state_e                 state_q;
    logic [NFRAMES_W-1:0]   nframes_q;
    logic [NFRAMES_W-1:0]   frame_cnt_q;
    logic [CW-1:0]          chan_cnt_q;
    logic [ADDR_W-1:0]      addr_q;
    logic                   full_q;
    logic                   done_q;
    logic                   ovf_q;
    logic                   buf_we_q;
    logic [ADDR_W-1:0]      buf_addr_q;
    logic [DATA_W-1:0]      buf_data_q;

    logic                   start_edge;
    logic                   abort;
    logic                   cap_go;
    logic                   ctrl_unused;
    logic [NFRAMES_W-1:0]   nf_in;
    logic [NFRAMES_W-1:0]   frame_nxt;
    logic [CW-1:0]          chan_nxt;
    logic [ADDR_W-1:0]      addr_nxt;

    chan_pkt_edge_det u_start_edge (
        .clk_i  (user_clk),
        .rst_i  (user_rst),
        .d_i    (ctrl_word[START_BIT]),
        .rise_o (start_edge)
    );

    assign abort       = ctrl_word[ABORT_BIT];
    assign nf_in       = ctrl_word[NFRAMES_LSB +: NFRAMES_W];
    assign ctrl_unused = ^ctrl_word[NFRAMES_LSB-1:ABORT_BIT+1];
    assign cap_go      = !abort && state_q == S_ARMED && sync_in && ch_valid;
    assign frame_nxt   = frame_cnt_q + NFRAMES_W'(1);
    assign chan_nxt    = chan_cnt_q + CW'(1);
    assign addr_nxt    = addr_q + ADDR_W'(1);

    // Capture FSM with registered write port; abort overrides everything, full_q marks a completed address lap
    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            state_q     <= S_IDLE;
            nframes_q   <= '0;
            frame_cnt_q <= '0;
            chan_cnt_q  <= '0;
            addr_q      <= '0;
            full_q      <= 1'b0;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
            buf_we_q    <= 1'b0;
            buf_addr_q  <= '0;
            buf_data_q  <= '0;
        end else begin
            buf_we_q   <= 1'b0;
            buf_data_q <= ch_data;
            if (abort) begin
                state_q <= S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE, S_DONE: begin
                        if (start_edge) begin
                            state_q     <= S_ARMED;
                            nframes_q   <= (nf_in == '0) ? NFRAMES_W'(1) : nf_in;
                            frame_cnt_q <= '0;
                            chan_cnt_q  <= '0;
                            addr_q      <= '0;
                            full_q      <= 1'b0;
                            done_q      <= 1'b0;
                            ovf_q       <= 1'b0;
                        end
                    end
                    S_ARMED: begin
                        if (cap_go) begin
                            state_q    <= S_CAPTURE;
                            buf_we_q   <= 1'b1;
                            buf_addr_q <= '0;
                            addr_q     <= ADDR_W'(1);
                            chan_cnt_q <= CW'(1);
                        end
                    end
                    S_CAPTURE: begin
                        if (ch_valid) begin
                            buf_we_q   <= 1'b1;
                            buf_addr_q <= addr_q;
                            addr_q     <= addr_nxt;
                            if (&addr_q) full_q <= 1'b1;
                            if (full_q) ovf_q <= 1'b1;
                            if (sync_in && chan_cnt_q != '0) begin
                                ovf_q      <= 1'b1;
                                chan_cnt_q <= CW'(1);
                            end else begin
                                chan_cnt_q <= chan_nxt;
                                if (chan_cnt_q == LAST_CH) begin
                                    frame_cnt_q <= frame_nxt;
                                    if (frame_nxt == nframes_q) begin
                                        state_q <= S_DONE;
                                        done_q  <= 1'b1;
                                    end
                                end
                            end
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    // Status word assembled from registered state only
    always_comb begin
        status = '0;
        status[BUSY_BIT] = (state_q == S_ARMED) || (state_q == S_CAPTURE);
        status[DONE_BIT] = done_q;
        status[OVF_BIT]  = ovf_q;
        status[FRAMES_LSB +: NFRAMES_W] = frame_cnt_q;
    end

    assign buf_we   = buf_we_q;
    assign buf_addr = buf_addr_q;
    assign buf_data = buf_data_q;

`ifdef CHAN_PKT_START_TIMESTAMP_EN
    logic [31:0] cyc_q;
    logic [31:0] ts_q;

    // Free-running cycle counter, stamped on the cycle the first sample of a capture is accepted
    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            cyc_q <= '0;
            ts_q  <= '0;
        end else begin
            cyc_q <= cyc_q + 32'd1;
            if (cap_go) ts_q <= cyc_q;
        end
    end

    assign ts_out = ts_q;
`endif

endmodule

// File: tb/tb_chan_512_packet_start_ctrl.sv
// tb_chan_512_packet_start_ctrl: randomized scoreboard bench; expected writes come from the capture plan
module tb_chan_512_packet_start_ctrl;

    typedef struct packed {
        logic [15:0] a;
        logic [31:0] d;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ctrl_word;
    logic        sync_in;
    logic        ch_valid;
    logic [31:0] ch_data;
    logic        buf_we;
    logic [15:0] buf_addr;
    logic [31:0] buf_data;
    logic [31:0] status;

    int   n_chk = 0;
    int   n_err = 0;
    int   exp_addr = 0;
    wr_t  exp_q[$];
    logic [31:0] exp_ts = 0;
    logic [31:0] cyc_m = 0;

`ifdef CHAN_PKT_START_TIMESTAMP_EN
    logic [31:0] ts_out;
`endif

    chan_512_packet_start_ctrl dut (
        .user_clk  (clk),
        .user_rst  (rst),
        .ctrl_word (ctrl_word),
        .sync_in   (sync_in),
        .ch_valid  (ch_valid),
        .ch_data   (ch_data),
        .buf_we    (buf_we),
        .buf_addr  (buf_addr),
        .buf_data  (buf_data),
        .status    (status)
`ifdef CHAN_PKT_START_TIMESTAMP_EN
        ,
        .ts_out    (ts_out)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_m <= rst ? 32'd0 : cyc_m + 32'd1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout required finish");
        $fatal(1, "watchdog");
    end

    always @(negedge clk) begin
        if (buf_we) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_write: got addr=%0d data=%h required no write", buf_addr, buf_data);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                if (buf_addr !== w.a || buf_data !== w.d) begin
                    n_err++;
                    $display("FAIL write: got addr=%0d data=%h required addr=%0d data=%h",
                             buf_addr, buf_data, w.a, w.d);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    task automatic cyc(input logic v, input logic s, input logic [31:0] d);
        ch_valid = v;
        sync_in  = s;
        ch_data  = d;
        @(posedge clk);
        #1;
    endtask

    // sy: 0 no sync, 1 sync on first sample (realign), 2 sync on first sample that arms capture
    task automatic stream(input int n, input int sy, input bit wr, input bit gaps);
        logic [31:0] d;
        for (int i = 0; i < n; i++) begin
            while (gaps && $urandom_range(3) == 0) cyc(1'b0, 1'b0, $urandom);
            d = $urandom;
            if (wr) begin
                exp_q.push_back({16'(exp_addr), d});
                exp_addr++;
                if (i == 0 && sy == 2) exp_ts = cyc_m;
            end
            cyc(1'b1, i == 0 && sy != 0, d);
        end
        cyc(1'b0, 1'b0, 32'd0);
    endtask

    task automatic start(input int nf);
        ctrl_word = {16'(nf), 16'h0000};
        cyc(1'b0, 1'b0, 32'd0);
        ctrl_word = {16'(nf), 16'h0001};
        cyc(1'b0, 1'b0, 32'd0);
        exp_addr = 0;
    endtask

    task automatic settle(input string nm);
        repeat (3) cyc(1'b0, 1'b0, 32'd0);
        chk(nm, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic chk_ts();
`ifdef CHAN_PKT_START_TIMESTAMP_EN
        chk("ts_out", ts_out, exp_ts);
`endif
    endtask

    initial begin
        rst = 1'b1;
        ctrl_word = 32'd0;
        sync_in = 1'b0;
        ch_valid = 1'b0;
        ch_data = 32'd0;
        repeat (3) cyc(1'b1, 1'b0, $urandom);
        chk("reset_we", 32'(buf_we), 32'd0);
        chk("reset_addr", 32'(buf_addr), 32'd0);
        chk("reset_data", buf_data, 32'd0);
        chk("reset_status", status, 32'd0);
        ch_valid = 1'b0;
        rst = 1'b0;
        cyc(1'b0, 1'b0, 32'd0);

        // two frames, continuous valid
        start(2);
        chk("armed_status", status, 32'h0000_0001);
        stream(5, 0, 1'b0, 1'b0);
        stream(1024, 2, 1'b1, 1'b0);
        stream(20, 2, 1'b0, 1'b0);
        settle("pending_2frames");
        chk("status_2frames", status, 32'h0002_0002);
        chk_ts();

        // num_frames 0 behaves as 1
        start(0);
        chk("rearm_status", status, 32'h0000_0001);
        stream(512, 2, 1'b1, 1'b1);
        settle("pending_nf0");
        chk("status_nf0", status, 32'h0001_0002);
        chk_ts();

        // misaligned sync at channel 100 realigns and flags overflow
        start(1);
        stream(100, 2, 1'b1, 1'b1);
        chk("busy_mid", status, 32'h0000_0001);
        stream(512, 1, 1'b1, 1'b1);
        settle("pending_realign");
        chk("status_realign", status, 32'h0001_0006);

        // abort at write 300
        start(1);
        stream(300, 2, 1'b1, 1'b0);
        ctrl_word = 32'h0001_0003;
        cyc(1'b1, 1'b0, $urandom);
        chk("abort_we", 32'(buf_we), 32'd0);
        chk("abort_status", status, 32'h0000_0000);
        ctrl_word = 32'h0001_0000;
        stream(10, 2, 1'b0, 1'b0);
        settle("pending_abort");
        start(1);
        stream(512, 2, 1'b1, 1'b1);
        settle("pending_after_abort");
        chk("status_after_abort", status, 32'h0001_0002);

        // start held high across DONE does not re-arm
        repeat (4) cyc(1'b0, 1'b0, 32'd0);
        stream(20, 2, 1'b0, 1'b0);
        settle("pending_held");
        chk("status_held", status, 32'h0001_0002);
        start(2);
        chk("toggle_rearm", status, 32'h0000_0001);
        stream(1024, 2, 1'b1, 1'b1);
        settle("pending_toggle");
        chk("status_toggle", status, 32'h0002_0002);

        // reset mid-capture stops writes
        start(1);
        stream(50, 2, 1'b1, 1'b0);
        settle("pending_prerst");
        rst = 1'b1;
        ctrl_word = 32'd0;
        cyc(1'b1, 1'b0, $urandom);
        cyc(1'b1, 1'b1, $urandom);
        chk("rst_mid_we", 32'(buf_we), 32'd0);
        chk("rst_mid_status", status, 32'd0);
        rst = 1'b0;
        stream(10, 2, 1'b0, 1'b0);
        settle("pending_postrst");

        // randomized frame counts with ARMED noise
        for (int k = 0; k < 3; k++) begin
            int nf;
            nf = $urandom_range(1, 3);
            start(nf);
            stream($urandom_range(0, 5), 0, 1'b0, 1'b1);
            stream(nf * 512, 2, 1'b1, 1'b1);
            stream(8, 2, 1'b0, 1'b0);
            settle("pending_rand");
            chk("status_rand", status, {16'(nf), 16'h0002});
            chk_ts();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
